mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4-input datapath mux among four requesters (e.g. four sources contending for one shared register-file write port or memory bus).
- Generates the registered 2-bit mux select and a one-hot grant.
- Drives the existing mux4 instance internally, so downstream logic sees one arbitrated word plus a valid flag.
- Enforces a maximum hold time so no requester can starve the others.

---
 rtl/mux4_rr_arbiter_pkg.sv | 33 +++
 rtl/mux4.sv | 29 ++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 26 ++
 rtl/mux4_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the mux4 round-robin arbiter slice.
//   - select encodings for the four requester inputs
//   - arbiter FSM state encoding
//   - control-register struct (state, rotation pointer, hold counter)
//   - one-hot helper for turning a winner index into a grant vector
package mux4_rr_arbiter_pkg;

    localparam logic [1:0] SEL_IN1 = 2'd0;
    localparam logic [1:0] SEL_IN2 = 2'd1;
    localparam logic [1:0] SEL_IN3 = 2'd2;
    localparam logic [1:0] SEL_IN4 = 2'd3;

    // Hold counter width; MAX_HOLD is limited to 1..255 so MAX_HOLD-1 fits.
    localparam int HOLD_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // All arbiter control state lives in one struct so checkers can watch
    // the FSM state, pointer and hold count through a single signal.
    typedef struct packed {
        arb_state_e          state;
        logic [1:0]          ptr;
        logic [HOLD_W-1:0]   hold;
    } arb_ctl_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4.sv
// Plain 4:1 datapath multiplexer.
//   sel              : 2-bit address, 00 selects in1 ... 11 selects in4
//   in1..in4         : data inputs, width bits each
//   out              : selected data
module mux4
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [1:0]       sel,
    input  logic [width-1:0] in1,
    input  logic [width-1:0] in2,
    input  logic [width-1:0] in3,
    input  logic [width-1:0] in4,
    output logic [width-1:0] out
);

    always_comb begin
        out = in1;
        unique case (sel)
            SEL_IN1: out = in1;
            SEL_IN2: out = in2;
            SEL_IN3: out = in3;
            SEL_IN4: out = in4;
            default: out = in1;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rr_pick4: combinational rotate-priority encoder.
//   req[3:0]    : candidate request vector
//   ptr[1:0]    : index searched first; search continues ascending mod 4
//   found       : at least one candidate bit is set
//   winner[1:0] : first set index in search order (equals ptr when !found)
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] winner
);

    // Walk the search order backwards so the earliest position in the
    // rotation is the last assignment and therefore wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                found  = 1'b1;
                winner = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one 4-input mux among four
// requesters, with a bounded hold time so no requester starves the others.
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   req[3:0]   : level requests, bit i = requester i
//   in1..in4   : requester 0..3 data
//   grant[3:0] : registered one-hot grant, zero when idle
//   select[1:0]: registered mux select (holds its last value when idle)
//   out        : in[select], combinational from the registered select
//   out_valid  : OR of grant
//
// Output qualification: out carries meaningful data only in cycles where
// out_valid is high; there is no backpressure, the consumer must accept the
// word in every cycle out_valid is asserted.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int width    = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic [width-1:0] in1,
    input  logic [width-1:0] in2,
    input  logic [width-1:0] in3,
    input  logic [width-1:0] in4,
    output logic [3:0]       grant,
    output logic [1:0]       select,
    output logic [width-1:0] out,
    output logic             out_valid
);

    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD - 1);

    arb_ctl_t   ctl_q, ctl_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] select_q, select_d;

    logic [3:0] cand;
    logic       found;
    logic [1:0] winner;
    logic       take;

    // Masking out the current owner gives the right candidate set in every
    // case: in IDLE grant is zero (all requests compete), on release the
    // owner bit is already clear, and on preemption the owner must be
    // excluded.
    assign cand = req & ~grant_q;

    rr_pick4 u_pick (
        .req    (cand),
        .ptr    (ctl_q.ptr),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        ctl_d    = ctl_q;
        grant_d  = grant_q;
        select_d = select_q;
        take     = 1'b0;

        unique case (ctl_q.state)
            ST_IDLE: begin
                if (found) take = 1'b1;
            end
            ST_OWNED: begin
                if (!req[select_q]) begin
                    // Owner released: hand off directly if anyone waits.
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        ctl_d.state = ST_IDLE;
                        ctl_d.hold  = '0;
                        grant_d     = '0;
                    end
                end else if (ctl_q.hold == HOLD_SAT) begin
                    // Hold budget used up: rotate only if a competitor waits,
                    // otherwise the sole requester keeps the port.
                    if (found) take = 1'b1;
                end else begin
                    ctl_d.hold = ctl_q.hold + HOLD_W'(1);
                end
            end
            default: ;
        endcase

        if (take) begin
            ctl_d.state = ST_OWNED;
            ctl_d.ptr   = winner + 2'd1;
            ctl_d.hold  = '0;
            grant_d     = onehot4(winner);
            select_d    = winner;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctl_q    <= '{state: ST_IDLE, ptr: 2'd0, hold: '0};
            grant_q  <= '0;
            select_q <= SEL_IN1;
        end else begin
            ctl_q    <= ctl_d;
            grant_q  <= grant_d;
            select_q <= select_d;
        end
    end

    assign grant     = grant_q;
    assign select    = select_q;
    assign out_valid = |grant_q;

    mux4 #(
        .width (width)
    ) u_mux (
        .sel (select_q),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .in4 (in4),
        .out (out)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter. Three instances with MAX_HOLD = 1, 2 and 4
// share the same stimulus; each is compared against its own copy of a
// cycle-level reference model of the arbitration rules.
module tb_mux4_rr_arbiter;

    localparam int W = 32;
    localparam int N = 3;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req;
    logic [W-1:0] in1, in2, in3, in4;

    logic [3:0]   grant     [N];
    logic [1:0]   select    [N];
    logic [W-1:0] out       [N];
    logic         out_valid [N];

    int checks   = 0;
    int failures = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int MH = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        mux4_rr_arbiter #(
            .width    (W),
            .MAX_HOLD (MH)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .req       (req),
            .in1       (in1),
            .in2       (in2),
            .in3       (in3),
            .in4       (in4),
            .grant     (grant[g]),
            .select    (select[g]),
            .out       (out[g]),
            .out_valid (out_valid[g])
        );
    end

    // ---------------- reference model ----------------
    // owner = -1 when idle; held = number of cycles the owner has had the
    // grant so far (1 on the first granted cycle).
    int mh      [N] = '{1, 2, 4};
    int m_owner [N];
    int m_sel   [N];
    int m_ptr   [N];
    int m_held  [N];

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    function automatic logic [W-1:0] data_of(input int s);
        case (s)
            0: return in1;
            1: return in2;
            2: return in3;
            default: return in4;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_owner[i] = -1;
            m_sel[i]   = 0;
            m_ptr[i]   = 0;
            m_held[i]  = 0;
        end
    endtask

    task automatic model_take(input int i, input int w);
        m_owner[i] = w;
        m_sel[i]   = w;
        m_ptr[i]   = (w + 1) % 4;
        m_held[i]  = 1;
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int w;
            logic [3:0] others;
            if (m_owner[i] < 0) begin
                w = pick(req, m_ptr[i]);
                if (w >= 0) model_take(i, w);
            end else if (!req[m_owner[i]]) begin
                w = pick(req, m_ptr[i]);
                if (w >= 0) model_take(i, w);
                else m_owner[i] = -1;
            end else if (m_held[i] >= mh[i]) begin
                others = req;
                others[m_owner[i]] = 1'b0;
                w = pick(others, m_ptr[i]);
                if (w >= 0) model_take(i, w);
                else m_held[i]++;
            end else begin
                m_held[i]++;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            logic [3:0] exp_g;
            exp_g = (m_owner[i] < 0) ? 4'b0000 : 4'(1 << m_owner[i]);
            chk($sformatf("%s_grant_g%0d", tag, i), W'(grant[i]), W'(exp_g));
            chk($sformatf("%s_select_g%0d", tag, i), W'(select[i]), W'(m_sel[i]));
            chk($sformatf("%s_out_g%0d", tag, i), out[i], data_of(m_sel[i]));
            chk($sformatf("%s_valid_g%0d", tag, i), W'(out_valid[i]), W'(m_owner[i] >= 0));
            chk($sformatf("%s_onehot_g%0d", tag, i), W'($onehot0(grant[i])), W'(1));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: assert reset, check the reset state, then
    // release it before the next rising edge with req = r.
    task automatic reset_phase(input logic [3:0] r, input string tag);
        reset_n = 1'b0;
        req     = r;
        #2;
        model_reset();
        check_all(tag);
        reset_n = 1'b1;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    // ---------------- stimulus ----------------
    logic [3:0]   rr_seq  [9];
    logic [W-1:0] rr_data [4];

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        in1     = 32'hAAAA_0001;
        in2     = 32'hBBBB_0002;
        in3     = 32'hCCCC_0003;
        in4     = 32'hDDDD_0004;
        model_reset();
        @(negedge clk);

        // Reset with all requesting, then first grant after release.
        reset_phase(4'b1111, "rst");
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_grant_const_g%0d", i), W'(grant[i]), W'(4'b0000));
            chk($sformatf("rst_out_in1_g%0d", i), out[i], 32'hAAAA_0001);
        end
        tick("rst_rel");
        for (int i = 0; i < N; i++)
            chk($sformatf("rst_first_grant_g%0d", i), W'(grant[i]), W'(4'b0001));

        // Round robin with all requesting (MAX_HOLD=2 instance, directed).
        rr_seq  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                    4'b1000, 4'b1000, 4'b0001};
        rr_data = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        @(negedge clk);
        reset_phase(4'b1111, "rr_rst");
        for (int k = 0; k < 9; k++) begin
            tick("rr");
            chk($sformatf("rr_seq%0d", k), W'(grant[1]), W'(rr_seq[k]));
            chk($sformatf("rr_data%0d", k), out[1], rr_data[(k / 2) % 4]);
        end

        // Single requester held for 20 cycles, then dropped.
        reset_phase(4'b0100, "single_rst");
        for (int k = 0; k < 20; k++) begin
            tick("single");
            chk($sformatf("single_grant_c%0d", k), W'(grant[2]), W'(4'b0100));
        end
        req = 4'b0000;
        tick("single_drop");
        for (int i = 0; i < N; i++) begin
            chk($sformatf("drop_grant_g%0d", i), W'(grant[i]), W'(4'b0000));
            chk($sformatf("drop_select_g%0d", i), W'(select[i]), W'(2'b10));
        end

        // Release with handoff: owner 1 (ptr=2) drops while 0 and 3 raise.
        reset_phase(4'b0010, "handoff_rst");
        tick("handoff_own");
        req = 4'b1001;
        tick("handoff");
        for (int i = 0; i < N; i++)
            chk($sformatf("handoff_grant_g%0d", i), W'(grant[i]), W'(4'b1000));

        // Preemption on the MAX_HOLD=4 instance.
        reset_phase(4'b0001, "preempt_rst");
        tick("preempt_c1");
        tick("preempt_c2");
        tick("preempt_c3");
        req = 4'b0101;
        tick("preempt_c4");
        chk("preempt_hold_last", W'(grant[2]), W'(4'b0001));
        tick("preempt_sw");
        chk("preempt_switch", W'(grant[2]), W'(4'b0100));

        // Asynchronous reset while requester 3 owns the port.
        reset_phase(4'b1000, "midrst_pre");
        tick("midrst_own");
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("midrst_grant_g%0d", i), W'(grant[i]), W'(4'b0000));
            chk($sformatf("midrst_valid_g%0d", i), W'(out_valid[i]), W'(1'b0));
        end
        model_reset();
        req = 4'b1010;
        #1;
        reset_n = 1'b1;
        tick("midrst_rel");
        for (int i = 0; i < N; i++)
            chk($sformatf("midrst_regrant_g%0d", i), W'(grant[i]), W'(4'b0010));

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            in1 = $urandom;
            in2 = $urandom;
            in3 = $urandom;
            in4 = $urandom;
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
